// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP transmit/receive datapath.
package ssp_pkg;

   localparam int SSP_DATA_WIDTH = 8;
   localparam int CLK_DIV_MIN    = 2;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      LOAD,
      WAIT_FS,
      FRAME,
      SHIFT
   } tx_state_t;

endpackage

// File: rtl/ssp_clk_div.sv
// Free-running serial clock generator: SSPCLKOUT = PCLK / (2*CLK_DIV), with
// single-PCLK strobes flagging the cycle before each SSPCLKOUT edge.
module ssp_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic PCLK,
   input  logic CLEAR,
   output logic SSPCLKOUT,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic          sclk_q, sclk_d;
   logic          wrap;

   always_comb begin
      wrap      = (div_cnt_q == CW'(CLK_DIV - 1));
      div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
      sclk_d    = wrap ? ~sclk_q : sclk_q;
      // Strobes lead the edge so consumers update in step with SSPCLKOUT.
      rise_tick = wrap && !sclk_q;
      fall_tick = wrap && sclk_q;
   end

   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         div_cnt_q <= '0;
         sclk_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         sclk_q    <= sclk_d;
      end
   end

   assign SSPCLKOUT = sclk_q;

endmodule

// File: rtl/ssp_tx_shifter.sv
// SSP transmit serializer: pops words from the TX FIFO and sends them MSB-first
// in TI frame format, prefetching the next word into a hold register.
module ssp_tx_shifter
   import ssp_pkg::*;
#(
   parameter int DATA_WIDTH = SSP_DATA_WIDTH,
   parameter int CLK_DIV    = 2
) (
   input  logic                  PCLK,
   input  logic                  CLEAR,
   input  logic [DATA_WIDTH-1:0] TxData,
   input  logic                  fifo_empty,
   output logic                  shf_read_ready,
   output logic                  SSPTXD,
   output logic                  SSPFSSOUT,
   output logic                  SSPCLKOUT,
   output logic                  SSPOE_B,
   output logic                  tx_busy
);

   localparam int BW = $clog2(DATA_WIDTH);

   tx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  txd_q, txd_d;
   logic                  fss_q, fss_d;
   logic                  oe_b_q, oe_b_d;
   logic                  pf_armed_q, pf_armed_d;
   logic                  pf_cap_q, pf_cap_d;
   logic                  pf_pop;
   logic                  rise_tick;
   logic                  fall_tick;

   ssp_clk_div #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_div (
      .PCLK      (PCLK),
      .CLEAR     (CLEAR),
      .SSPCLKOUT (SSPCLKOUT),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      bit_cnt_d    = bit_cnt_q;
      txd_d        = txd_q;
      fss_d        = fss_q;
      oe_b_d       = oe_b_q;
      pf_armed_d   = 1'b0;

      // Prefetch window is the single PCLK right after bit_cnt reaches 1.
      pf_pop   = (state_q == SHIFT) && pf_armed_q && !hold_valid_q && !fifo_empty;
      pf_cap_d = pf_pop;

      if (pf_cap_q) begin
         hold_d       = TxData;
         hold_valid_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = REQ;
         end
         REQ: begin
            state_d = LOAD;
         end
         LOAD: begin
            shift_d = TxData;
            state_d = WAIT_FS;
         end
         WAIT_FS: begin
            if (rise_tick) begin
               fss_d   = 1'b1;
               oe_b_d  = 1'b0;
               state_d = FRAME;
            end
         end
         FRAME: begin
            if (rise_tick) begin
               fss_d     = 1'b0;
               txd_d     = shift_q[DATA_WIDTH-1];
               bit_cnt_d = BW'(DATA_WIDTH - 1);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (rise_tick) begin
               if (bit_cnt_q == '0) begin
                  txd_d = 1'b0;
                  if (hold_valid_q) begin
                     shift_d      = hold_q;
                     hold_valid_d = 1'b0;
                     fss_d        = 1'b1;
                     state_d      = FRAME;
                  end else begin
                     oe_b_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  txd_d      = shift_q[bit_cnt_q - 1'b1];
                  bit_cnt_d  = bit_cnt_q - 1'b1;
                  pf_armed_d = (bit_cnt_q == BW'(2));
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      shf_read_ready = (state_q == REQ) || pf_pop;
   end

   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         bit_cnt_q    <= '0;
         txd_q        <= 1'b0;
         fss_q        <= 1'b0;
         oe_b_q       <= 1'b1;
         pf_armed_q   <= 1'b0;
         pf_cap_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         bit_cnt_q    <= bit_cnt_d;
         txd_q        <= txd_d;
         fss_q        <= fss_d;
         oe_b_q       <= oe_b_d;
         pf_armed_q   <= pf_armed_d;
         pf_cap_q     <= pf_cap_d;
      end
   end

   assign SSPTXD    = txd_q;
   assign SSPFSSOUT = fss_q;
   assign SSPOE_B   = oe_b_q;
   assign tx_busy   = (state_q != IDLE);

   ap_pop_single : assert property (@(posedge PCLK) disable iff (CLEAR)
      shf_read_ready |=> !shf_read_ready);
   ap_pop_nonempty : assert property (@(posedge PCLK) disable iff (CLEAR)
      shf_read_ready |-> !fifo_empty);
   ap_ticks_exclusive : assert property (@(posedge PCLK)
      !(rise_tick && fall_tick));
   ap_prefetch_done : assert property (@(posedge PCLK) disable iff (CLEAR)
      (state_q == SHIFT && rise_tick && bit_cnt_q == '0) |-> (!pf_cap_q && !pf_pop));

endmodule

// File: tb/tb_ssp_tx_shifter.sv
// Randomized self-checking bench for ssp_tx_shifter at CLK_DIV=2 and CLK_DIV=4.
module tb_ssp_tx_shifter;
   import ssp_pkg::*;

   logic PCLK  = 1'b0;
   logic CLEAR = 1'b1;
   always #5 PCLK = ~PCLK;

   logic [7:0] txdata_a = '0, txdata_b = '0;
   logic       empty_a = 1'b1, empty_b = 1'b1;
   logic       rr_a, txd_a, fss_a, sclk_a, oeb_a, busy_a;
   logic       rr_b, txd_b, fss_b, sclk_b, oeb_b, busy_b;

   ssp_tx_shifter #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_a (
      .PCLK(PCLK), .CLEAR(CLEAR), .TxData(txdata_a), .fifo_empty(empty_a),
      .shf_read_ready(rr_a), .SSPTXD(txd_a), .SSPFSSOUT(fss_a),
      .SSPCLKOUT(sclk_a), .SSPOE_B(oeb_a), .tx_busy(busy_a));

   ssp_tx_shifter #(.DATA_WIDTH(8), .CLK_DIV(4)) dut_b (
      .PCLK(PCLK), .CLEAR(CLEAR), .TxData(txdata_b), .fifo_empty(empty_b),
      .shf_read_ready(rr_b), .SSPTXD(txd_b), .SSPFSSOUT(fss_b),
      .SSPCLKOUT(sclk_b), .SSPOE_B(oeb_b), .tx_busy(busy_b));

   int checks = 0;
   int failures = 0;
   int sel = 0;
   int pops = 0, dbl_pops = 0, empty_pops = 0;
   logic [7:0] fq_a[$], fq_b[$], pend_a[$], pend_b[$];
   logic m_rr, m_txd, m_fss, m_sclk, m_oeb, m_busy, m_empty;
   logic prev_rr = 1'b0;

   always_comb begin
      if (sel == 0) {m_rr, m_txd, m_fss, m_sclk, m_oeb, m_busy, m_empty} =
                    {rr_a, txd_a, fss_a, sclk_a, oeb_a, busy_a, empty_a};
      else          {m_rr, m_txd, m_fss, m_sclk, m_oeb, m_busy, m_empty} =
                    {rr_b, txd_b, fss_b, sclk_b, oeb_b, busy_b, empty_b};
   end

   // FIFO models: one-cycle read latency, pushes land on the next PCLK edge.
   always @(posedge PCLK) begin
      if (CLEAR) begin
         fq_a.delete(); fq_b.delete(); pend_a.delete(); pend_b.delete();
         empty_a <= 1'b1;
         empty_b <= 1'b1;
      end else begin
         if (rr_a && fq_a.size() > 0) txdata_a <= fq_a.pop_front();
         if (rr_b && fq_b.size() > 0) txdata_b <= fq_b.pop_front();
         while (pend_a.size() > 0) fq_a.push_back(pend_a.pop_front());
         while (pend_b.size() > 0) fq_b.push_back(pend_b.pop_front());
         empty_a <= (fq_a.size() == 0);
         empty_b <= (fq_b.size() == 0);
      end
   end

   always @(negedge PCLK) begin
      if (CLEAR) prev_rr = 1'b0;
      else begin
         if (m_rr) begin
            pops++;
            if (prev_rr) dbl_pops++;
            if (m_empty) empty_pops++;
         end
         prev_rr = m_rr;
      end
   end

   task automatic push(input logic [7:0] v);
      if (sel == 0) pend_a.push_back(v);
      else pend_b.push_back(v);
   endtask

   // Waits for the next SSPCLKOUT rise; obs = {fss, txd, oe_b, read_ready}.
   task automatic next_period(output logic [3:0] obs, output int n, output bit ok);
      n = 0;
      while (m_sclk !== 1'b0 && n < 64) begin @(negedge PCLK); n++; end
      while (m_sclk !== 1'b1 && n < 64) begin @(negedge PCLK); n++; end
      ok  = (n < 64);
      obs = {m_fss, m_txd, m_oeb, m_rr};
   endtask

   task automatic wait_start(input string nm, output bit found);
      logic [3:0] obs;
      int n, tries;
      bit ok;
      tries = 0;
      do begin next_period(obs, n, ok); tries++; end
      while (ok && obs[1] !== 1'b0 && tries < 20);
      found = ok && (obs[1] === 1'b0) && (obs === 4'b1000);
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL %s frame_start: obs=%b after %0d periods, required 1000", nm, obs, tries);
      end
   endtask

   // Expected line activity: per word one FSS period then 8 data periods MSB
   // first; the next queued word is fetched during bit 1; one idle period ends.
   task automatic run_frames(input string nm, input logic [7:0] w[$],
                             input bit late_push, input logic [7:0] late_w);
      logic [3:0] obs, exp;
      int n, cd;
      bit ok, found;
      cd = (sel == 0) ? 2 : 4;
      wait_start(nm, found);
      if (!found) return;
      for (int i = 0; i < w.size(); i++) begin
         if (i > 0) begin
            next_period(obs, n, ok);
            checks++;
            if (!ok || obs !== 4'b1000) begin
               failures++;
               $display("FAIL %s fss word%0d: obs=%b required 1000", nm, i, obs);
            end
         end
         for (int b = 7; b >= 0; b--) begin
            next_period(obs, n, ok);
            exp = {1'b0, w[i][b], 1'b0, (b == 1 && i < w.size() - 1)};
            checks++;
            if (!ok || obs !== exp) begin
               failures++;
               $display("FAIL %s word%0d bit%0d: obs=%b required %b", nm, i, b, obs, exp);
            end
            checks++;
            if (n != 2 * cd) begin
               failures++;
               $display("FAIL %s period_len word%0d bit%0d: got %0d PCLK required %0d", nm, i, b, n, 2 * cd);
            end
            if (late_push && i == w.size() - 1 && b == 0) push(late_w);
         end
      end
      next_period(obs, n, ok);
      checks++;
      if (!ok || obs !== 4'b0010) begin
         failures++;
         $display("FAIL %s frame_end: obs=%b required 0010", nm, obs);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge PCLK);
      checks++;
      if ({txd_a, fss_a, oeb_a, rr_a, busy_a, sclk_a} !== 6'b001000) begin
         failures++;
         $display("FAIL reset_a: {txd,fss,oe_b,rd,busy,sclk}=%b required 001000",
                  {txd_a, fss_a, oeb_a, rr_a, busy_a, sclk_a});
      end
      checks++;
      if ({txd_b, fss_b, oeb_b, rr_b, busy_b, sclk_b} !== 6'b001000) begin
         failures++;
         $display("FAIL reset_b: {txd,fss,oe_b,rd,busy,sclk}=%b required 001000",
                  {txd_b, fss_b, oeb_b, rr_b, busy_b, sclk_b});
      end
      CLEAR = 1'b0;
   endtask

   task automatic test_idle();
      int bad = 0, spacing_bad = 0, toggles = 0, last_t = -1;
      logic ps;
      sel = 0;
      ps = m_sclk;
      for (int i = 0; i < 100; i++) begin
         @(negedge PCLK);
         if (m_rr || m_txd || m_fss || !m_oeb || m_busy) bad++;
         if (m_sclk !== ps) begin
            if (last_t >= 0 && i - last_t != 2) spacing_bad++;
            last_t = i;
            toggles++;
         end
         ps = m_sclk;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL idle_lines: %0d bad cycles, required 0", bad); end
      checks++;
      if (spacing_bad != 0) begin failures++; $display("FAIL idle_sclk_spacing: %0d bad, required 0", spacing_bad); end
      checks++;
      if (toggles != 50) begin failures++; $display("FAIL idle_sclk_toggles: %0d required 50", toggles); end
   endtask

   task automatic test_single();
      logic [7:0] wl[$];
      int p0 = pops;
      wl.push_back(8'hA5);
      push(8'hA5);
      run_frames("single_A5", wl, 1'b0, 8'h00);
      checks++;
      if (m_busy !== 1'b0) begin failures++; $display("FAIL single_busy: %b required 0", m_busy); end
      checks++;
      if (pops - p0 != 1) begin failures++; $display("FAIL single_pops: %0d required 1", pops - p0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] wl[$];
      int p0 = pops;
      wl.push_back(8'h3C); wl.push_back(8'hC3);
      push(8'h3C); push(8'hC3);
      run_frames("b2b_3C_C3", wl, 1'b0, 8'h00);
      checks++;
      if (pops - p0 != 2) begin failures++; $display("FAIL b2b_pops: %0d required 2", pops - p0); end
   endtask

   task automatic test_random_bursts();
      for (int k = 0; k < 4; k++) begin
         logic [7:0] wl[$];
         logic [7:0] v;
         int nw = $urandom_range(1, 3);
         int p0 = pops;
         for (int j = 0; j < nw; j++) begin
            v = 8'($urandom);
            wl.push_back(v);
            push(v);
         end
         run_frames("rand_burst", wl, 1'b0, 8'h00);
         checks++;
         if (pops - p0 != nw) begin failures++; $display("FAIL rand_pops: %0d required %0d", pops - p0, nw); end
      end
   endtask

   task automatic test_gap();
      logic [7:0] w0[$], w1[$];
      int p0 = pops;
      w0.push_back(8'h00);
      w1.push_back(8'h81);
      push(8'h00);
      run_frames("gap_00", w0, 1'b1, 8'h81);
      run_frames("gap_81", w1, 1'b0, 8'h00);
      checks++;
      if (pops - p0 != 2) begin failures++; $display("FAIL gap_pops: %0d required 2", pops - p0); end
   endtask

   task automatic test_clear_mid();
      logic [3:0] obs;
      int n, bad;
      bit ok, found;
      push(8'hFF);
      wait_start("clear_FF", found);
      for (int b = 0; b < 4; b++) next_period(obs, n, ok);
      CLEAR = 1'b1;
      @(negedge PCLK);
      CLEAR = 1'b0;
      checks++;
      if ({m_txd, m_fss, m_oeb, m_busy} !== 4'b0010) begin
         failures++;
         $display("FAIL clear_outputs: {txd,fss,oe_b,busy}=%b required 0010", {m_txd, m_fss, m_oeb, m_busy});
      end
      checks++;
      if (dut_a.state_q !== IDLE || dut_a.hold_valid_q !== 1'b0) begin
         failures++;
         $display("FAIL clear_state: state=%0d hold_valid=%b required IDLE/0", dut_a.state_q, dut_a.hold_valid_q);
      end
      bad = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge PCLK);
         if (!m_oeb || m_txd || m_fss || m_busy) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL clear_quiet: %0d active cycles required 0", bad); end
   endtask

   task automatic test_clkdiv4();
      logic [7:0] wl[$];
      logic [7:0] v;
      int p0;
      sel = 1;
      @(negedge PCLK);
      p0 = pops;
      v = 8'($urandom);
      wl.push_back(8'h5A); wl.push_back(v);
      push(8'h5A); push(v);
      run_frames("div4_5A", wl, 1'b0, 8'h00);
      checks++;
      if (pops - p0 != 2) begin failures++; $display("FAIL div4_pops: %0d required 2", pops - p0); end
   endtask

   task automatic test_protocol();
      checks++;
      if (dbl_pops != 0) begin failures++; $display("FAIL pop_consecutive: %0d required 0", dbl_pops); end
      checks++;
      if (empty_pops != 0) begin failures++; $display("FAIL pop_when_empty: %0d required 0", empty_pops); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_random_bursts();
      test_gap();
      test_clear_mid();
      test_clkdiv4();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
